mem_access_unit: RTL and testbench

Memory-stage load/store engine that consumes the EX/MEM pipeline register outputs and drives the data-memory bus. It converts the registered address, store data, read/write strobes and access type into a word-aligned bus transaction with byte strobes. It returns sign- or zero-extended load data toward MEM/WB, and holds the pipeline with `stall_o` until the access completes. It sits between the EX/MEM register and the MEM/WB register.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/mem_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: funct3 access types, FSM states,
// timeout counter width and the misalignment predicate.
package riscv_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        RW_B  = 3'b000,
        RW_H  = 3'b001,
        RW_W  = 3'b010,
        RW_BU = 3'b100,
        RW_HU = 3'b101
    } rw_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Unlisted funct3 codes behave as word accesses.
    function automatic logic is_misaligned(input logic [2:0] rw_type, input logic [1:0] off);
        case (rw_type)
            RW_B, RW_BU: return 1'b0;
            RW_H, RW_HU: return off[0];
            default:     return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for stores and lane extraction plus
// sign/zero extension for loads.
module mem_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_st_off,
    input  logic [2:0]  i_st_type,
    input  logic        i_st_we,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_ld_off,
    input  logic [2:0]  i_ld_type,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wdata = i_st_data;
        o_wstrb = 4'b1111;
        case (i_st_type)
            RW_B, RW_BU: begin
                o_wdata = {4{i_st_data[7:0]}};
                o_wstrb = 4'(4'b0001 << i_st_off);
            end
            RW_H, RW_HU: begin
                o_wdata = {2{i_st_data[15:0]}};
                o_wstrb = i_st_off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!i_st_we) o_wstrb = 4'b0000;
    end

    always_comb begin
        case (i_ld_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Half select ignores bit 0 so an untrapped odd address still lands on a half.
        w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ld_type)
            RW_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            RW_BU:   o_ld_data = {24'h0, w_byte};
            RW_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            RW_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: IDLE/REQ/DONE handshake to the data bus
// with pipeline stall. Optional MISALIGN_TRAP_EN traps misaligned H/W accesses.
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_result_i,
    input  logic [31:0] Rd_data2_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  RW_type_i,
    output logic        stall_o,
    output logic [31:0] Mem_data_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_wstrb_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i
);

    state_e            r_state, w_next;
    logic [31:0]       r_addr, r_wdata;
    logic [2:0]        r_type;
    logic              r_we;
    logic [3:0]        r_wstrb;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_arm;

    logic              w_acc, w_mis, w_stall, w_req, w_capture, w_ack, w_timeout;
    logic [31:0]       w_st_wdata, w_ld_data;
    logic [3:0]        w_st_wstrb;

    assign w_acc = MemRead_i | MemWrite_i;

`ifdef MISALIGN_TRAP_EN
    logic r_mis_arm;
    assign w_mis      = is_misaligned(RW_type_i, ALU_result_i[1:0]);
    assign misalign_o = (r_state == S_DONE) && r_mis_arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_mis_arm <= 1'b0;
        else if (w_capture) r_mis_arm <= w_mis;
    end
`else
    assign w_mis      = 1'b0;
    assign misalign_o = 1'b0;
`endif

    mem_align u_align (
        .i_st_off  (ALU_result_i[1:0]),
        .i_st_type (RW_type_i),
        .i_st_we   (MemWrite_i),
        .i_st_data (Rd_data2_i),
        .o_wstrb   (w_st_wstrb),
        .o_wdata   (w_st_wdata),
        .i_ld_off  (r_addr[1:0]),
        .i_ld_type (r_type),
        .i_rdata   (dbus_rdata_i),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_req     = 1'b0;
        w_capture = 1'b0;
        w_ack     = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_stall   = 1'b1;
                    w_capture = 1'b1;
                    w_next    = w_mis ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (dbus_ack_i) begin
                    w_ack  = 1'b1;
                    w_next = S_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Gate with rst so an access held on the strobes cannot re-stall during reset.
    assign stall_o      = w_stall & ~rst;
    assign dbus_req_o   = w_req;
    assign dbus_we_o    = w_req & r_we;
    assign dbus_addr_o  = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign dbus_wdata_o = w_req ? r_wdata : 32'h0;
    assign dbus_wstrb_o = w_req ? r_wstrb : 4'h0;
    assign bus_err_o    = (r_state == S_DONE) && r_err_arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_type     <= '0;
            r_we       <= 1'b0;
            r_wstrb    <= '0;
            r_cnt      <= '0;
            r_err_arm  <= 1'b0;
            Mem_data_o <= '0;
        end else begin
            if (w_capture) begin
                r_addr    <= ALU_result_i;
                r_wdata   <= w_st_wdata;
                r_type    <= RW_type_i;
                r_we      <= MemWrite_i;
                r_wstrb   <= w_st_wstrb;
                r_cnt     <= '0;
                r_err_arm <= 1'b0;
            end
            if (w_req && !w_ack && !w_timeout) r_cnt <= r_cnt + 1'b1;
            if (w_timeout) r_err_arm <= 1'b1;
            if (w_ack && !r_we) Mem_data_o <= w_ld_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT=8); expectations
// follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_result_i, Rd_data2_i, dbus_rdata_i;
    logic        MemRead_i, MemWrite_i, dbus_ack_i;
    logic [2:0]  RW_type_i;
    logic        stall_o, misalign_o, bus_err_o, dbus_req_o, dbus_we_o;
    logic [31:0] Mem_data_o, dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_wstrb_o;

    int total = 0;
    int bad   = 0;

    int          st_c, rq_c;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_strb;
    logic        b_we, mis_s, err_s;

    mem_access_unit #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ALU_result_i (ALU_result_i),
        .Rd_data2_i   (Rd_data2_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .RW_type_i    (RW_type_i),
        .stall_o      (stall_o),
        .Mem_data_o   (Mem_data_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_wstrb_o (dbus_wstrb_o),
        .dbus_ack_i   (dbus_ack_i),
        .dbus_rdata_i (dbus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one access from IDLE (entered at posedge+1) through DONE and back to IDLE.
    // waits = REQ cycles without ack before ack is given.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] t,
                          input int waits, input logic [31:0] rword);
        logic done;
        MemWrite_i = w; MemRead_i = r; ALU_result_i = a; Rd_data2_i = d; RW_type_i = t;
        st_c = 0; rq_c = 0; mis_s = 0; err_s = 0; done = 0;
        b_addr = '0; b_wdata = '0; b_strb = '0; b_we = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (!stall_o) begin
                mis_s = misalign_o;
                err_s = bus_err_o;
                done  = 1;
            end else begin
                st_c++;
                dbus_ack_i = 1'b0;
                if (dbus_req_o) begin
                    rq_c++;
                    if (rq_c == 1) begin
                        b_addr = dbus_addr_o; b_wdata = dbus_wdata_o;
                        b_strb = dbus_wstrb_o; b_we = dbus_we_o;
                    end
                    if (rq_c == waits + 1) begin
                        dbus_ack_i = 1'b1;
                        dbus_rdata_i = rword;
                    end
                end
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            total++; bad++;
            $error("FAIL access_bound: observed=stall_stuck expected=done");
        end
        dbus_ack_i = 1'b0; MemWrite_i = 1'b0; MemRead_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        ALU_result_i = '0; Rd_data2_i = '0; dbus_rdata_i = '0;
        MemRead_i = 0; MemWrite_i = 0; dbus_ack_i = 0; RW_type_i = 3'b000;
        #1;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_req",   32'(dbus_req_o), 32'h0);
        chk("rst_mem",   Mem_data_o, 32'h0);
        chk("rst_addr",  dbus_addr_o, 32'h0);
        chk("rst_flags", {29'h0, misalign_o, bus_err_o, dbus_we_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // SW 0x100
        access(1, 0, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0);
        chk("sw_addr",  b_addr, 32'h100);
        chk("sw_strb",  32'(b_strb), 32'hF);
        chk("sw_wdata", b_wdata, 32'hDEADBEEF);
        chk("sw_we",    32'(b_we), 32'h1);
        chk("sw_stall", st_c, 2);

        // SB 0x103
        access(1, 0, 32'h103, 32'h000000A5, 3'b000, 0, 32'h0);
        chk("sb_wdata", b_wdata, 32'hA5A5A5A5);
        chk("sb_strb",  32'(b_strb), 32'h8);

        // SH 0x102
        access(1, 0, 32'h102, 32'h1234BEEF, 3'b001, 0, 32'h0);
        chk("sh_wdata", b_wdata, 32'hBEEFBEEF);
        chk("sh_strb",  32'(b_strb), 32'hC);

        // LB / LBU 0x103
        access(0, 1, 32'h103, 32'h0, 3'b000, 0, 32'hA5000000);
        chk("lb_data", Mem_data_o, 32'hFFFFFFA5);
        chk("lb_strb", 32'(b_strb), 32'h0);
        chk("lb_we",   32'(b_we), 32'h0);
        access(0, 1, 32'h103, 32'h0, 3'b100, 0, 32'hA5000000);
        chk("lbu_data", Mem_data_o, 32'h000000A5);

        // LH with 4 wait cycles, LHU 0x102
        access(0, 1, 32'h102, 32'h0, 3'b001, 4, 32'h80010000);
        chk("lh_data",  Mem_data_o, 32'hFFFF8001);
        chk("lh_stall", st_c, 6);
        chk("lh_req",   rq_c, 5);
        access(0, 1, 32'h102, 32'h0, 3'b101, 0, 32'h80010000);
        chk("lhu_data", Mem_data_o, 32'h00008001);
        chk("lhu_err",  32'(err_s), 32'h0);

        // No ack: timeout after 8 REQ cycles
        access(0, 1, 32'h200, 32'h0, 3'b010, 1000, 32'h0);
        chk("to_req",   rq_c, 8);
        chk("to_stall", st_c, 9);
        chk("to_err",   32'(err_s), 32'h1);
        chk("to_mem",   Mem_data_o, 32'h00008001);
        chk("to_err_clr", 32'(bus_err_o), 32'h0);
        chk("to_idle",  32'(stall_o), 32'h0);

        // Ack outside REQ is ignored
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("stray_ack_stall", 32'(stall_o), 32'h0);
        @(posedge clk); #1;
        chk("stray_ack_mem", Mem_data_o, 32'h00008001);
        dbus_ack_i = 1'b0;

        // LW 0x102
        access(0, 1, 32'h102, 32'h0, 3'b010, 0, 32'hCAFEF00D);
`ifdef MISALIGN_TRAP_EN
        chk("lwm_req",   rq_c, 0);
        chk("lwm_mis",   32'(mis_s), 32'h1);
        chk("lwm_stall", st_c, 1);
        chk("lwm_mem",   Mem_data_o, 32'h00008001);
`else
        chk("lwm_addr",  b_addr, 32'h100);
        chk("lwm_mis",   32'(mis_s), 32'h0);
        chk("lwm_mem",   Mem_data_o, 32'hCAFEF00D);
`endif
        chk("lwm_mis_clr", 32'(misalign_o), 32'h0);

        // Reset during REQ
        MemRead_i = 1'b1; ALU_result_i = 32'h104; RW_type_i = 3'b010;
        @(posedge clk); #1;
        chk("mid_req", 32'(dbus_req_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req",   32'(dbus_req_o), 32'h0);
        chk("mid_rst_stall", 32'(stall_o), 32'h0);
        chk("mid_rst_mem",   Mem_data_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; MemRead_i = 1'b0;
        @(posedge clk); #1;
        access(0, 1, 32'h104, 32'h0, 3'b010, 0, 32'h13579BDF);
        chk("post_rst_mem",   Mem_data_o, 32'h13579BDF);
        chk("post_rst_addr",  b_addr, 32'h104);
        chk("post_rst_stall", st_c, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
